// File: rtl/sobel_stream_engine.sv
// Streaming 3x3 Sobel edge engine, valid/ready in and out. Latency: 4 pipeline advances.
// Backpressure: whole pipeline stalls while an output beat is held; optional SOBEL_EDGE_COUNT_EN adds a frame edge counter.
module sobel_stream_engine #(
    parameter int DATA_WIDTH     = 8,
    parameter int MAX_LINE_WIDTH = 1920,
    parameter int CNT_WIDTH      = 24
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid_in,
    output logic                    o_ready_in,
    input  logic [DATA_WIDTH-1:0]   i_data_in,
    input  logic                    i_sof_in,
    input  logic                    i_eol_in,
    input  logic [1:0]              i_mode,
    input  logic [DATA_WIDTH+2:0]   i_thresh,
    output logic                    o_valid_out,
    input  logic                    i_ready_out,
    output logic [DATA_WIDTH-1:0]   o_data_out,
    output logic                    o_sof_out,
    output logic                    o_eol_out,
    output logic                    o_err,
    output logic [CNT_WIDTH-1:0]    o_edge_count
);
    localparam int AW = $clog2(MAX_LINE_WIDTH);
    localparam int GW = DATA_WIDTH + 3;
    localparam int BW = DATA_WIDTH + 2;

    typedef enum logic [1:0] {ROW0, ROW1, ACTIVE} row_t;

    row_t                  row_q, row_d, row_eff;
    logic [AW-1:0]         col_q, col_d, col_eff;
    logic                  err_d, en, acc, mask_in;
    logic [DATA_WIDTH-1:0] lb0 [MAX_LINE_WIDTH];
    logic [DATA_WIDTH-1:0] lb1 [MAX_LINE_WIDTH];
    logic [DATA_WIDTH-1:0] rd0, rd1;
    logic [DATA_WIDTH-1:0] win [3][3];

    logic                  s1_vld, s1_mask, s1_sof, s1_eol;
    logic                  s2_vld, s2_mask, s2_sof, s2_eol;
    logic                  s3_vld, s3_mask, s3_sof, s3_eol;
    logic signed [GW-1:0]  s2_gx, s2_gy, gx_c, gy_c;
    logic [BW-1:0]         s3_ax, s3_ay;
    logic [GW-1:0]         sum_c;
    logic [DATA_WIDTH-1:0] val_c;

    assign en         = !o_valid_out || i_ready_out;
    assign o_ready_in = en;
    assign acc        = i_valid_in && en;

    // sof restarts geometry before the beat itself is placed
    always_comb begin
        row_eff = i_sof_in ? ROW0 : row_q;
        col_eff = i_sof_in ? '0 : col_q;
        mask_in = (row_eff != ACTIVE) || (col_eff < AW'(2));
        row_d   = row_q;
        col_d   = col_q;
        err_d   = o_err;
        if (acc) begin
            row_d = row_eff;
            col_d = col_eff + 1'b1;
            if (i_eol_in) begin
                col_d = '0;
                case (row_eff)
                    ROW0:    row_d = ROW1;
                    default: row_d = ACTIVE;
                endcase
            end else if (col_eff == AW'(MAX_LINE_WIDTH - 1)) begin
                col_d = '0;
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            row_q <= ROW0;
            col_q <= '0;
            o_err <= 1'b0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            o_err <= err_d;
        end
    end

    assign rd0 = lb0[col_eff];
    assign rd1 = lb1[col_eff];

    // Line buffers and window hold pixel data only; they need no reset.
    always_ff @(posedge i_clk) begin
        if (acc) begin
            lb0[col_eff] <= i_data_in;
            lb1[col_eff] <= rd0;
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= rd1;
            win[1][2] <= rd0;
            win[2][2] <= i_data_in;
        end
    end

    function automatic logic signed [GW-1:0] ext(input logic [DATA_WIDTH-1:0] p);
        return $signed({3'b000, p});
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sat(input logic [GW-1:0] v);
        return (v > GW'({DATA_WIDTH{1'b1}})) ? {DATA_WIDTH{1'b1}} : v[DATA_WIDTH-1:0];
    endfunction

    assign gx_c = ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2])
                - ext(win[0][0]) - (ext(win[1][0]) <<< 1) - ext(win[2][0]);
    assign gy_c = ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(win[2][2])
                - ext(win[0][0]) - (ext(win[0][1]) <<< 1) - ext(win[0][2]);

    always_ff @(posedge i_clk) begin
        if (en) begin
            s2_gx <= gx_c;
            s2_gy <= gy_c;
            s3_ax <= BW'(s2_gx[GW-1] ? -s2_gx : s2_gx);
            s3_ay <= BW'(s2_gy[GW-1] ? -s2_gy : s2_gy);
        end
    end

    assign sum_c = GW'(s3_ax) + GW'(s3_ay);

    always_comb begin
        val_c = '0;
        case (i_mode)
            2'd0:    val_c = sat(sum_c);
            2'd1:    val_c = sat(GW'(s3_ax));
            2'd2:    val_c = sat(GW'(s3_ay));
            default: val_c = (sum_c >= i_thresh) ? {DATA_WIDTH{1'b1}} : '0;
        endcase
        if (s3_mask) val_c = '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            {s1_vld, s1_mask, s1_sof, s1_eol} <= '0;
            {s2_vld, s2_mask, s2_sof, s2_eol} <= '0;
            {s3_vld, s3_mask, s3_sof, s3_eol} <= '0;
            o_valid_out <= 1'b0;
            o_data_out  <= '0;
            o_sof_out   <= 1'b0;
            o_eol_out   <= 1'b0;
        end else if (en) begin
            {s1_vld, s1_mask, s1_sof, s1_eol} <= {acc, mask_in, i_sof_in, i_eol_in};
            {s2_vld, s2_mask, s2_sof, s2_eol} <= {s1_vld, s1_mask, s1_sof, s1_eol};
            {s3_vld, s3_mask, s3_sof, s3_eol} <= {s2_vld, s2_mask, s2_sof, s2_eol};
            o_valid_out <= s3_vld;
            o_data_out  <= val_c;
            o_sof_out   <= s3_sof;
            o_eol_out   <= s3_eol;
        end
    end

`ifdef SOBEL_EDGE_COUNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;

    // A frame's total is published when the next frame's first beat leaves the engine.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q        <= '0;
            o_edge_count <= '0;
        end else if (en && s3_vld) begin
            if (s3_sof) begin
                o_edge_count <= cnt_q;
                cnt_q        <= '0;
            end else if (!s3_mask && sum_c >= i_thresh && cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
`else
    assign o_edge_count = '0;
`endif
endmodule

// File: tb/tb_sobel_stream_engine.sv
// Bench for sobel_stream_engine: table-driven pattern frames, stall/overflow/reset sequences and random frames.
module tb_sobel_stream_engine;
    localparam int DW = 8, MLW = 16, CW = 24, W = 8, H = 6;

    logic          i_clk = 1'b0, i_rst_n = 1'b0;
    logic          i_valid_in = 1'b0, i_sof_in = 1'b0, i_eol_in = 1'b0, i_ready_out = 1'b1;
    logic [DW-1:0] i_data_in = '0;
    logic [1:0]    i_mode = '0;
    logic [DW+2:0] i_thresh = '0;
    logic          o_ready_in, o_valid_out, o_sof_out, o_eol_out, o_err;
    logic [DW-1:0] o_data_out;
    logic [CW-1:0] o_edge_count;

    sobel_stream_engine #(.DATA_WIDTH(DW), .MAX_LINE_WIDTH(MLW), .CNT_WIDTH(CW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid_in(i_valid_in), .o_ready_in(o_ready_in),
        .i_data_in(i_data_in), .i_sof_in(i_sof_in), .i_eol_in(i_eol_in), .i_mode(i_mode),
        .i_thresh(i_thresh), .o_valid_out(o_valid_out), .i_ready_out(i_ready_out),
        .o_data_out(o_data_out), .o_sof_out(o_sof_out), .o_eol_out(o_eol_out),
        .o_err(o_err), .o_edge_count(o_edge_count));

    always #5 i_clk = ~i_clk;

    typedef struct { int pat; int mode; int thresh; int exp_nz; } vec_t;
    typedef struct { logic [DW-1:0] data; logic sof; logic eol; } beat_t;

    int    img [0:7][0:15];
    beat_t cap [$];
    int    cap_base = 0;
    int    n_cmp = 0, n_err = 0;
    bit    sending;

    always @(negedge i_clk)
        if (i_rst_n && o_valid_out && i_ready_out)
            cap.push_back('{o_data_out, o_sof_out, o_eol_out});

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int satv(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Reference: direct 3x3 Sobel on the stored image, masked at the top two rows and left two columns.
    function automatic int model(input int r, input int c, input int mode, input int th);
        int gx, gy, ax, ay;
        if (r < 2 || c < 2) return 0;
        gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c]) - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
        gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c]) - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        case (mode)
            0:       return satv(ax + ay);
            1:       return satv(ax);
            2:       return satv(ay);
            default: return (ax + ay >= th) ? 255 : 0;
        endcase
    endfunction

    task automatic fill(input int pat, input int w, input int h);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                case (pat)
                    0: img[r][c] = 100;
                    1: img[r][c] = (c < 4) ? 0 : 200;
                    2: img[r][c] = 10 * r;
                    3: img[r][c] = 20 * r;
                    default: img[r][c] = int'($urandom_range(0, 255));
                endcase
    endtask

    task automatic send_beat(input int d, input bit sof, input bit eol, input bit gaps);
        int  t;
        bit  a;
        if (gaps) while ($urandom_range(0, 3) == 0) begin @(posedge i_clk); #1; end
        i_valid_in = 1'b1; i_data_in = DW'(d); i_sof_in = sof; i_eol_in = eol;
        t = 0; a = 1'b0;
        while (!a && t < 300) begin
            @(negedge i_clk); a = o_ready_in;
            @(posedge i_clk); #1; t++;
        end
        if (!a) check("accept_timeout", 0, 1);
        i_valid_in = 1'b0; i_sof_in = 1'b0; i_eol_in = 1'b0;
    endtask

    task automatic send_frame(input int w, input int h, input bit gaps);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                send_beat(img[r][c], (r == 0 && c == 0), (c == w - 1), gaps);
    endtask

    task automatic wait_caps(input int n);
        int t = 0;
        while (cap.size() - cap_base < n && t < 3000) begin @(posedge i_clk); #1; t++; end
        repeat (6) @(posedge i_clk);
        #1;
    endtask

    task automatic compare_frame(input int w, input int h, input int mode, input int th,
                                 input string nm, output int nz);
        beat_t b;
        int    r, c, e;
        nz = 0;
        wait_caps(w * h);
        check({nm, "_beats"}, cap.size() - cap_base, w * h);
        if (cap.size() - cap_base >= w * h) begin
            for (int i = 0; i < w * h; i++) begin
                b = cap[cap_base + i];
                r = i / w; c = i % w;
                e = model(r, c, mode, th);
                if (b.data != 0) nz++;
                check($sformatf("%s_r%0d_c%0d", nm, r, c), {b.data, b.sof, b.eol},
                      {DW'(e), (r == 0 && c == 0), (c == w - 1)});
            end
        end
        cap_base = cap.size();
    endtask

    task automatic pulse_reset();
        i_rst_n = 1'b0; i_valid_in = 1'b0;
        #1;
        check("rst_valid_now", o_valid_out, 0);
        repeat (3) begin @(negedge i_clk); check("rst_valid_hold", o_valid_out, 0); end
        @(posedge i_clk); #1;
        cap_base = cap.size();
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
    endtask

    initial begin
        vec_t  tbl [6];
        int    nz, k, w, h, mode, th, t;
        logic [31:0] hold;

        tbl[0] = '{0, 0,   0,  0};
        tbl[1] = '{1, 0, 100,  8};
        tbl[2] = '{1, 2, 100,  0};
        tbl[3] = '{2, 3, 100,  0};
        tbl[4] = '{3, 3, 100, 24};
        tbl[5] = '{1, 1,  50,  8};

        repeat (3) @(posedge i_clk);
        #1;
        check("rst_outputs", {o_valid_out, o_data_out, o_sof_out, o_eol_out, o_err}, 0);
        check("rst_edge_count", o_edge_count, 0);
        check("rst_ready_in", o_ready_in, 1);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        for (int i = 0; i < 6; i++) begin
            fill(tbl[i].pat, W, H);
            i_mode = tbl[i].mode; i_thresh = 11'(tbl[i].thresh);
            if (i == 0) begin
                k = 0;
                fork
                    send_frame(W, H, 1'b0);
                    while (!o_valid_out && k < 20) begin @(posedge i_clk); #1; k++; end
                join
                check("first_latency", k, 4);
            end else begin
                send_frame(W, H, 1'b0);
            end
            compare_frame(W, H, tbl[i].mode, tbl[i].thresh, $sformatf("tbl%0d", i), nz);
            check($sformatf("tbl%0d_nonzero", i), nz, tbl[i].exp_nz);
            if (i == 2) begin
`ifdef SOBEL_EDGE_COUNT_EN
                check("edge_count_step", o_edge_count, 8);
`else
                check("edge_count_off", o_edge_count, 0);
`endif
            end
        end

        // Mid-line output stall on the step frame.
        fill(1, W, H);
        i_mode = 2'd0; i_thresh = 11'd100;
        fork
            send_frame(W, H, 1'b0);
            begin
                t = 0;
                while (cap.size() - cap_base < 20 && t < 500) begin @(posedge i_clk); #1; t++; end
                i_ready_out = 1'b0;
                hold = {23'd0, o_valid_out, o_data_out};
                check("stall_valid", o_valid_out, 1);
                repeat (5) begin
                    @(negedge i_clk);
                    check("stall_ready_in", o_ready_in, 0);
                    check("stall_hold", {23'd0, o_valid_out, o_data_out}, hold);
                    @(posedge i_clk); #1;
                end
                i_ready_out = 1'b1;
            end
        join
        compare_frame(W, H, 0, 100, "stall", nz);
        check("stall_nonzero", nz, 8);

        for (int f = 0; f < 6; f++) begin
            w = int'($urandom_range(3, 16)); h = int'($urandom_range(3, 8));
            fill(9, w, h);
            mode = int'($urandom_range(0, 3)); th = int'($urandom_range(0, 600));
            i_mode = 2'(mode); i_thresh = 11'(th);
            sending = 1'b1;
            fork
                begin send_frame(w, h, 1'b1); sending = 1'b0; end
                begin
                    while (sending) begin i_ready_out = ($urandom_range(0, 3) != 0); @(posedge i_clk); #1; end
                    i_ready_out = 1'b1;
                end
            join
            compare_frame(w, h, mode, th, $sformatf("rnd%0d", f), nz);
        end

        // Line overflow: 20 beats with no eol on a 16-deep line.
        check("err_before", o_err, 0);
        for (int i = 0; i < 20; i++) begin
            send_beat(i, (i == 0), 1'b0, 1'b0);
            if (i == 14) check("err_beat15", o_err, 0);
            if (i == 15) check("err_beat16", o_err, 1);
        end
        wait_caps(20);
        cap_base = cap.size();
        fill(9, W, H);
        i_mode = 2'd0;
        send_frame(W, H, 1'b0);
        compare_frame(W, H, 0, 0, "after_err", nz);
        check("err_sticky", o_err, 1);

        // Reset in the middle of a frame, then a fresh frame.
        fill(9, W, H);
        for (int i = 0; i < 3 * W + 3; i++) send_beat(img[i / W][i % W], (i == 0), (i % W == W - 1), 1'b0);
        pulse_reset();
        check("err_cleared", o_err, 0);
        fill(9, W, H);
        i_mode = 2'd3; i_thresh = 11'd150;
        send_frame(W, H, 1'b0);
        compare_frame(W, H, 3, 150, "post_rst", nz);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
